// File: rtl/pep9_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// pep9_bus_arbiter_if
//
// Bundles the signals around the Pep9 SystemBus arbiter:
//   - requester 0 (CPU):    req0, addr0, wdata0, we0 -> ack0
//   - requester 1 (loader): req1, addr1, wdata1, we1 -> ack1
//   - shared results:       rdata, err, busy, owner
//   - SystemBus side:       address, DatatoWrite, we -> DatatoRead, DoneMem
//
// Modports:
//   slave  - the arbiter. It samples requests and bus responses and drives
//            acks, results and the bus command.
//   master - the environment around the arbiter: both requesters plus the
//            memory responding on the SystemBus.
//
// Handshake: reqN is a level. The arbiter answers each granted request
// with exactly one single-cycle ackN pulse; rdata/err are valid while that
// ack is high and hold until the next ack. The requester drops reqN on the
// edge where it samples ackN=1; a reqN still high in IDLE is a new request.
// On the SystemBus the command (address/DatatoWrite/we) is stable from the
// cycle after grant until the edge at which DoneMem=1 is sampled.
// ---------------------------------------------------------------------------
interface pep9_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  // requester 0
  logic          req0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          we0;
  logic          ack0;
  // requester 1
  logic          req1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          we1;
  logic          ack1;
  // shared results
  logic [DW-1:0] rdata;
  logic          err;
  logic          busy;
  logic          owner;
  // SystemBus
  logic [AW-1:0] address;
  logic [DW-1:0] DatatoWrite;
  logic          we;
  logic [DW-1:0] DatatoRead;
  logic          DoneMem;

  modport slave (
    input  req0, addr0, wdata0, we0,
    input  req1, addr1, wdata1, we1,
    input  DatatoRead, DoneMem,
    output ack0, ack1, rdata, err, busy, owner,
    output address, DatatoWrite, we
  );

  modport master (
    output req0, addr0, wdata0, we0,
    output req1, addr1, wdata1, we1,
    output DatatoRead, DoneMem,
    input  ack0, ack1, rdata, err, busy, owner,
    input  address, DatatoWrite, we
  );
endinterface

// File: rtl/pep9_bus_arbiter.sv
// ---------------------------------------------------------------------------
// pep9_bus_arbiter
//
// Shares one Pep9 SystemBus memory port between requester 0 (CPU) and
// requester 1 (program loader / debug). Grants round-robin, runs a single
// byte transaction on the bus, waits for DoneMem and returns read data with
// a one-cycle acknowledge. A transaction that never sees DoneMem is aborted
// after TIMEOUT cycles in BUSY and acknowledged with err=1.
//
// Parameters:
//   TIMEOUT - max cycles spent in BUSY waiting for DoneMem (>= 2)
//   AW      - address width
//   DW      - data width
//
// Ports:
//   Sysclk    - clock, all logic on the rising edge
//   reset     - synchronous, active-high reset
//   bus       - pep9_bus_arbiter_if.slave (requests, acks, results, bus)
//   dbg_state - current FSM state (0=IDLE, 1=BUSY, 2=DONE)
//
// Timing (edge E = grant edge):
//   E        : IDLE samples a request, registers the bus command, -> BUSY
//   E+1..    : BUSY, command frozen on the bus, waiting for DoneMem
//   E+k      : DoneMem=1 (or timeout) sampled -> DONE, ack/rdata/err set
//   E+k+1    : DONE -> IDLE, ack cleared
//   Minimum request-to-ack is 2 edges; back-to-back turnaround is one
//   idle cycle.
// ---------------------------------------------------------------------------
module pep9_bus_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int AW      = 16,
  parameter int DW      = 8
) (
  input  logic                Sysclk,
  input  logic                reset,
  pep9_bus_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state
);

  // One extra bit on top of clog2 so TIMEOUT-1 always fits; the abort
  // fires at TIMEOUT-1, so the counter never wraps.
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;

  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;     // last-granted requester
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Grant selection in IDLE. With both requesting, the one that was not
  // granted last wins; the pointer resets to 1 so requester 0 wins the
  // first tie.
  logic          grant;
  logic          any_req;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;

  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      grant = ~last_q;
    end else begin
      grant = bus.req1;
    end
    sel_addr  = grant ? bus.addr1  : bus.addr0;
    sel_wdata = grant ? bus.wdata1 : bus.wdata0;
    sel_we    = grant ? bus.we1    : bus.we0;
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Sysclk) begin
    if (reset) begin
      state_q <= IDLE;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // Defaults: hold everything, acks are single-cycle pulses.
    state_d = state_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = grant;
          last_d  = grant;
          addr_d  = sel_addr;
          // Reads never put stale write data on the bus.
          wdata_d = sel_we ? sel_wdata : '0;
          we_d    = sel_we;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          // Bus parked at zero; DoneMem is ignored here.
          addr_d  = '0;
          wdata_d = '0;
          we_d    = 1'b0;
        end
      end

      BUSY: begin
        // DoneMem is tested first so that it wins over a timeout landing
        // on the same edge.
        if (bus.DoneMem) begin
          rdata_d = we_q ? '0 : bus.DatatoRead;
          err_d   = 1'b0;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          addr_d  = '0;
          wdata_d = '0;
          we_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          addr_d  = '0;
          wdata_d = '0;
          we_d    = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        // Ack was raised on entry; one cycle here, then back to IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata       = rdata_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.owner       = owner_q;
  assign bus.address     = addr_q;
  assign bus.DatatoWrite = wdata_q;
  assign bus.we          = we_q;
  assign dbg_state       = state_q;

endmodule

// File: doc/pep9_bus_arbiter.md
Name: pep9_bus_arbiter

Overview:
Two-requester arbiter and transaction sequencer for the Pep9 SystemBus memory port. It shares one SystemBus between requester 0 (Pep9 CPU memory interface) and requester 1 (program loader / debug port). It grants round-robin, drives address, data and write-enable for one byte transaction, waits for DoneMem, and returns the read data with a one-cycle acknowledge. A timeout aborts transactions that never complete.

Parameters:
TIMEOUT, 64, max cycles in BUSY waiting for DoneMem before aborting with error (>=2)
AW, 16, address width
DW, 8, data width

Ports:
Sysclk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 (CPU) transaction request, level
addr0  input  AW  requester 0 address
wdata0  input  DW  requester 0 write data
we0  input  1  requester 0 write enable (1=write, 0=read)
ack0  output  1  one-cycle completion pulse to requester 0
req1  input  1  requester 1 (loader) request, level
addr1  input  AW  requester 1 address
wdata1  input  DW  requester 1 write data
we1  input  1  requester 1 write enable
ack1  output  1  one-cycle completion pulse to requester 1
rdata  output  DW  read data, valid while ack0/ack1 high
err  output  1  timeout flag, valid while ack0/ack1 high
busy  output  1  high in BUSY and DONE states
owner  output  1  index of current/last granted requester
address  output  AW  to SystemBus address
DatatoWrite  output  DW  to SystemBus write data
we  output  1  to SystemBus write enable
DatatoRead  input  DW  from SystemBus read data
DoneMem  input  1  from SystemBus, transaction complete

Behaviour:
- Reset values: state IDLE; ack0=ack1=0; rdata=0; err=0; busy=0; owner=0; address=0; DatatoWrite=0; we=0; last-grant pointer=1, so requester 0 wins the first tie; timeout counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: bus outputs held at 0. DoneMem is ignored.
- IDLE, request present: exactly one request is granted. If both are high, the requester other than last-grant wins.
- On grant: owner, last-grant, address, DatatoWrite and we are registered from the winning requester's inputs. DatatoWrite is forced to 0 on reads. Counter is cleared. Next state is BUSY.
- BUSY: address, DatatoWrite and we stay frozen. Requester inputs are not re-sampled.
- BUSY, DoneMem=1 at an edge:
  - rdata <= DatatoRead for a read, 0 for a write.
  - err <= 0.
  - ack[owner] <= 1.
  - we, address and DatatoWrite <= 0.
  - Next state is DONE.
- BUSY, DoneMem=0: counter increments. When the counter reaches TIMEOUT-1 without DoneMem, the transaction aborts: ack[owner] <= 1, err <= 1, rdata <= 0, bus outputs <= 0, next state DONE.
- DoneMem and timeout on the same edge: DoneMem wins and err=0.
- DONE: lasts exactly one cycle with ack high, then returns to IDLE with ack cleared. rdata and err hold until the next ack.
- Requester rule: a requester must drop reqN on the edge where it samples ackN=1. If reqN is still high in IDLE, it is treated as a new request.
- Latency:
  - Request seen at edge E.
  - Bus drive becomes visible after E.
  - DoneMem sampled at edge E+k gives ack high during cycle E+k to E+k+1.
  - Minimum request-to-ack is 2 edges.
  - Back-to-back turnaround is 1 idle cycle.
- Fairness: under continuous requests on both sides, grants strictly alternate.
- Reset mid-transaction: immediate return to IDLE with all reset values. No ack is issued for the aborted transaction. The pointer is reset to 1.
- Counter width: clog2(TIMEOUT)+1 bits. It never wraps, because the abort occurs first.

Test Plan:
- Reset, then req0 read addr0=0x0000, bus model returns DatatoRead=0x61 with DoneMem 3 cycles after address is driven -> ack0 pulses once, rdata=0x61, err=0, ack1 stays 0.
- req1 write addr1=0x0010 with wdata1=0xA5 -> address=0x0010, DatatoWrite=0xA5 and we=1 are held stable until DoneMem. After ack1, rdata=0x00 and we=0.
- req0 and req1 both asserted after reset and re-asserted after each ack for 6 transactions -> grant order is 0,1,0,1,0,1 and owner matches each ack.
- TIMEOUT=8 and DoneMem never asserted on a req0 read -> ack0 arrives 8 cycles after grant with err=1 and rdata=0. The next request is served normally.
- reset asserted 2 cycles into BUSY -> next cycle all outputs are 0, no ack is issued, state is IDLE. A following simultaneous request is granted to requester 0.
- DoneMem pulsed while IDLE -> no ack and no state change.
